// File: rtl/distance_pkg.sv
// Shared definitions for the distance display path.
// Contents:
//   BCD_W          - bits per BCD digit
//   DEFAULT_WIDTH  - default binary distance width (cm)
//   DEFAULT_DIGITS - default number of BCD digits shown
//   ST_*           - FSM state encodings for the sequential BCD converter
//   pow10()        - elaboration-time helper for the width/digit range check
package distance_pkg;

    localparam int unsigned BCD_W          = 4;
    localparam int unsigned DEFAULT_WIDTH  = 12;
    localparam int unsigned DEFAULT_DIGITS = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so the
// following left shift carries into the next decimal digit.
// Ports:
//   i_Digit - 4-bit BCD scratch digit
//   o_Digit - corrected digit (i_Digit >= 5 ? i_Digit + 3 : i_Digit)
module bcd_add3
    import distance_pkg::*;
(
    input  logic [BCD_W-1:0] i_Digit,
    output logic [BCD_W-1:0] o_Digit
);

    always_comb begin
        o_Digit = i_Digit;
        if (i_Digit >= 4'd5) begin
            o_Digit = i_Digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock)
// for the distance display. Results feed the 7-segment decoders directly.
// Ports:
//   i_Clk    - clock, rising edge
//   i_Reset  - synchronous active-high reset
//   i_Start  - convert i_Bin (accepted in IDLE or DONE only)
//   i_Bin    - unsigned binary distance, WIDTH bits
//   o_Busy   - high while shifting
//   o_Done   - one-cycle pulse when o_Bcd/o_Blank are updated
//   o_Bcd    - result digits, digit k in bits [4k+3:4k], k=0 is ones
//   o_Blank  - leading-zero blank flags; bit 0 is never set
module bin2bcd_seq
    import distance_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned DIGITS = DEFAULT_DIGITS
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic                      i_Start,
    input  logic [WIDTH-1:0]          i_Bin,
    output logic                      o_Busy,
    output logic                      o_Done,
    output logic [BCD_W*DIGITS-1:0]   o_Bcd,
    output logic [DIGITS-1:0]         o_Blank
);

    localparam int unsigned SCR_W = BCD_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    // Every WIDTH-bit value must fit in DIGITS decimal digits; there is no
    // saturation logic, so an undersized configuration is rejected outright.
    if (!(pow10(DIGITS) > ((64'd1 << WIDTH) - 64'd1))) begin : g_width_check
        $fatal(1, "bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [WIDTH-1:0]   op_q,      op_d;
    logic [SCR_W-1:0]   bcd_q,     bcd_d;
    logic [DIGITS-1:0]  blank_q,   blank_d;

    logic [SCR_W-1:0]   corr;
    logic [DIGITS-1:0]  blank_next;
    logic               all_zero;
    logic               shift_unused;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_Digit (scratch_q[g*BCD_W +: BCD_W]),
            .o_Digit (corr[g*BCD_W +: BCD_W])
        );
    end

    // Blank flags walk down from the most significant digit; bit 0 stays 0.
    always_comb begin
        blank_next = '0;
        all_zero   = 1'b1;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            all_zero      = all_zero & (scratch_q[k*BCD_W +: BCD_W] == 4'd0);
            blank_next[k] = all_zero;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        scratch_d    = scratch_q;
        op_d         = op_q;
        bcd_d        = bcd_q;
        blank_d      = blank_q;
        shift_unused = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_Start) begin
                    op_d      = i_Bin;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = ST_SHIFT;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // WIDTH shift cycles bring the counter to 0; the extra cycle
                // at 0 only publishes the scratch digits.
                if (cnt_q == '0) begin
                    bcd_d   = scratch_q;
                    blank_d = blank_next;
                    state_d = ST_DONE;
                end else begin
                    // Top digit's MSB shifts out; it is always 0 given the range check.
                    {shift_unused, scratch_d, op_d} = {corr, op_q, 1'b0};
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            scratch_q <= '0;
            op_q      <= '0;
            bcd_q     <= '0;
            blank_q   <= BLANK_RST;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            op_q      <= op_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
        end
    end

    assign o_Busy  = (state_q == ST_SHIFT);
    assign o_Done  = (state_q == ST_DONE);
    assign o_Bcd   = bcd_q;
    assign o_Blank = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vectors with literal
// expectations plus a cycle-level reference model compared every cycle.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 12;
    localparam int DIGITS = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .i_Start (start),
        .i_Bin   (bin),
        .o_Busy  (busy),
        .o_Done  (done),
        .o_Bcd   (bcd),
        .o_Blank (blank)
    );

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int p10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
        return r;
    endfunction

    // Digit k and everything above it is zero exactly when v < 10^k.
    function automatic logic [DIGITS-1:0] ref_blank(input int v);
        logic [DIGITS-1:0] r;
        r = '0;
        for (int k = 1; k < DIGITS; k++) r[k] = (v < p10(k));
        return r;
    endfunction

    // Reference model: a start accepted while not busy makes the block busy
    // for WIDTH+1 cycles, after which the result appears with a done pulse.
    int                  m_left = 0;
    int                  m_val  = 0;
    logic                m_done;
    logic [4*DIGITS-1:0] m_bcd;
    logic [DIGITS-1:0]   m_blank;

    always @(posedge clk) begin
        if (rst) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_bcd   <= '0;
            m_blank <= ref_blank(0);
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                if (m_left == 1) begin
                    m_done  <= 1'b1;
                    m_bcd   <= ref_bcd(m_val);
                    m_blank <= ref_blank(m_val);
                end
                m_left <= m_left - 1;
            end else if (start) begin
                m_val  <= int'(bin);
                m_left <= WIDTH + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy",  busy,  (m_left > 0));
            check("cyc_done",  done,  m_done);
            check("cyc_bcd",   bcd,   m_bcd);
            check("cyc_blank", blank, m_blank);
        end
    end

    // Drives a one-cycle start; returns at the negedge after the sampling edge.
    task automatic start_conv(input int v);
        bin   = WIDTH'(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges after the start-sampling edge until o_Done is seen.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    int e, e2, ndone;
    logic [4*DIGITS-1:0] cap_bcd;
    logic [DIGITS-1:0]   cap_blank;
    int dec;
    bit digit_bad;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        check("rst_busy",  busy,  1'b0);
        check("rst_done",  done,  1'b0);
        check("rst_bcd",   bcd,   16'h0000);
        check("rst_blank", blank, 4'b1110);
        @(negedge clk);

        // Zero
        start_conv(0);
        wait_done(e);
        check("zero_done_seen", done, 1'b1);
        check("zero_latency", e, 13);
        check("zero_bcd", bcd, 16'h0000);
        check("zero_blank", blank, 4'b1110);

        // Maximum, then a small value
        start_conv(4095);
        wait_done(e);
        check("max_done_seen", done, 1'b1);
        check("max_latency", e, 13);
        check("max_bcd", bcd, 16'h4095);
        check("max_blank", blank, 4'b0000);
        start_conv(57);
        wait_done(e);
        check("v57_done_seen", done, 1'b1);
        check("v57_bcd", bcd, 16'h0057);
        check("v57_blank", blank, 4'b1100);

        // Back-to-back: start held during the DONE cycle
        start_conv(500);
        wait_done(e);
        check("b2b_first_done", done, 1'b1);
        check("b2b_first_bcd", bcd, 16'h0500);
        check("b2b_first_blank", blank, 4'b1000);
        bin   = 12'd1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_next", busy, 1'b1);
        e2 = 1;
        while (!done && e2 < 40) begin
            @(negedge clk);
            e2++;
        end
        check("b2b_second_done", done, 1'b1);
        check("b2b_cycles_between", e2 - 1, 13);
        check("b2b_bcd", bcd, 16'h1234);
        check("b2b_blank", blank, 4'b0000);
        @(negedge clk);

        // Start while busy is ignored, i_Bin changes have no effect
        start_conv(250);
        repeat (4) @(negedge clk);
        bin   = 12'd999;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = 12'd777;
        ndone = 0;
        cap_bcd = '0;
        cap_blank = '0;
        for (int i = 0; i < 35; i++) begin
            if (done) begin
                ndone++;
                cap_bcd   = bcd;
                cap_blank = blank;
            end
            @(negedge clk);
        end
        check("busy_start_done_count", ndone, 1);
        check("busy_start_bcd", cap_bcd, 16'h0250);
        check("busy_start_blank", cap_blank, 4'b1000);
        check("busy_start_idle_after", busy, 1'b0);

        // Reset mid-conversion, with start asserted alongside reset
        start_conv(3000);
        repeat (5) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        bin   = 12'd3000;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_bcd", bcd, 16'h0000);
        check("midrst_blank", blank, 4'b1110);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("midrst_no_done", ndone, 0);
        start_conv(3000);
        wait_done(e);
        check("fresh_done_seen", done, 1'b1);
        check("fresh_latency", e, 13);
        check("fresh_bcd", bcd, 16'h3000);
        check("fresh_blank", blank, 4'b0000);

        // Exhaustive sweep against decimal arithmetic
        for (int v = 0; v < 4096; v++) begin
            start_conv(v);
            wait_done(e);
            if (!done) begin
                check($sformatf("sweep_done_%0d", v), done, 1'b1);
            end else begin
                dec = 0;
                digit_bad = 1'b0;
                for (int k = DIGITS - 1; k >= 0; k--) begin
                    if (bcd[4*k +: 4] > 4'd9) digit_bad = 1'b1;
                    dec = dec * 10 + int'(bcd[4*k +: 4]);
                end
                if (digit_bad) dec = -1;
                check($sformatf("sweep_val_%0d", v), dec, v);
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
